debug_trace_buffer: RTL and testbench

Parametrised on-chip trace capture for core debug signals (PC, bus addresses, data); replaces fixed vendor debug probes with a triggerable ring buffer readable by firmware or a debug bridge. Sits beside the RiscV core in the FPGA top level. Continuously records valid samples once armed, stops a programmable number of samples after a masked-compare trigger, then serves the window oldest-first through a synchronous read port.

---
 rtl/debug_trace_buffer.sv | 148 ++++++++++++++
 tb/tb_debug_trace_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_buffer.sv
// Triggerable ring-buffer trace capture for core debug signals, read oldest-first.
// Optional macro TRACE_TIMESTAMP_EN prefixes each entry with a free-running cycle timestamp.
module debug_trace_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned TS_WIDTH   = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W   = TS_WIDTH + DATA_WIDTH
`else
    localparam int unsigned ENTRY_W   = DATA_WIDTH
`endif
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     sample_valid,
    input  logic [DATA_WIDTH-1:0]    sample_data,
    input  logic [DATA_WIDTH-1:0]    trig_value,
    input  logic [DATA_WIDTH-1:0]    trig_mask,
    input  logic [$clog2(DEPTH):0]   post_count,
    output logic [1:0]               state,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   entries,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ENTRY_W-1:0]       rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic                wrapped_q, wrapped_d;
    logic [CW-1:0]       entries_q, entries_d;
    logic [CW-1:0]       remaining_q, remaining_d;
    logic [ENTRY_W-1:0]  rd_data_q, rd_data_d;
    logic [ENTRY_W-1:0]  mem [DEPTH];

    logic                wr_en_c;
    logic                trig_hit_c;
    logic [ENTRY_W-1:0]  wr_entry_c;
    logic [AW-1:0]       oldest_c;
    logic [AW-1:0]       rd_idx_c;

    assign trig_hit_c = sample_valid && (((sample_data ^ trig_value) & trig_mask) == '0);

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_WIDTH'(1);
    end

    assign wr_entry_c = {ts_q, sample_data};
`else
    assign wr_entry_c = sample_data;
`endif

    // State register and capture bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wrapped_q   <= 1'b0;
            entries_q   <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wrapped_q   <= wrapped_d;
            entries_q   <= entries_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Next-state: abort beats arm; arm restarts capture from any state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wrapped_d   = wrapped_q;
        entries_d   = entries_q;
        remaining_d = remaining_q;
        wr_en_c     = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            entries_d = '0;
        end else if (arm) begin
            ptr_d       = '0;
            wrapped_d   = 1'b0;
            entries_d   = '0;
            remaining_d = (post_count > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : post_count;
            state_d     = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (sample_valid) begin
                        wr_en_c = 1'b1;
                        if (trig_hit_c) begin
                            state_d = (remaining_q == '0) ? DONE : TRIGGERED;
                        end
                    end
                end
                TRIGGERED: begin
                    if (sample_valid) begin
                        wr_en_c     = 1'b1;
                        remaining_d = remaining_q - CW'(1);
                        if (remaining_q == CW'(1)) state_d = DONE;
                    end
                end
                default: ;
            endcase

            if (wr_en_c) begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) wrapped_d = 1'b1;
                if (entries_q != CW'(DEPTH)) entries_d = entries_q + CW'(1);
            end
        end
    end

    // Read path maps logical index (0 = oldest) onto the ring; out-of-range reads return zero.
    assign oldest_c  = wrapped_q ? ptr_q : '0;
    assign rd_idx_c  = oldest_c + rd_addr;
    assign rd_data_d = (CW'(rd_addr) < entries_q) ? mem[rd_idx_c] : '0;

    always_ff @(posedge clock) begin
        if (wr_en_c) mem[ptr_q] <= wr_entry_c;
    end

    assign state   = state_q;
    assign done    = (state_q == DONE);
    assign entries = entries_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer with DEPTH=8; expected values are hand-derived constants.
module tb_debug_trace_buffer;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 8;
    localparam int unsigned TSW = 16;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned EW  = TSW + DW;
`else
    localparam int unsigned EW  = DW;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          arm;
    logic          abort;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic [DW-1:0] trig_value;
    logic [DW-1:0] trig_mask;
    logic [3:0]    post_count;
    logic [1:0]    state;
    logic          done;
    logic [3:0]    entries;
    logic [2:0]    rd_addr;
    logic [EW-1:0] rd_data;

    int checks = 0;
    int passes = 0;

    debug_trace_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEP),
        .TS_WIDTH  (TSW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .arm         (arm),
        .abort       (abort),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .post_count  (post_count),
        .state       (state),
        .done        (done),
        .entries     (entries),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_arm(input logic [3:0] pc);
        post_count = pc;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic feed(input int first, input int last);
        for (int v = first; v <= last; v++) begin
            sample_valid = 1'b1;
            sample_data  = DW'(v);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [63:0] exp);
        rd_addr = a;
        tick();
        chk(tag, 64'(rd_data), exp);
    endtask

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        trig_value   = '0;
        trig_mask    = '1;
        post_count   = '0;
        rd_addr      = '0;
        #12;
        chk("reset_state",   64'(state),   64'd0);
        chk("reset_done",    64'(done),    64'd0);
        chk("reset_entries", 64'(entries), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        reset = 1'b0;
        #2;

        // Basic trigger: value 5, post 2 -> samples 1..7 kept.
        trig_value = 32'd5;
        trig_mask  = 32'hFFFF_FFFF;
        do_arm(4'd2);
        chk("t1_armed", 64'(state), 64'd1);
        feed(1, 4);
        chk("t1_still_armed", 64'(state), 64'd1);
        feed(5, 5);
        chk("t1_triggered", 64'(state), 64'd2);
        feed(6, 10);
        chk("t1_state",   64'(state),   64'd3);
        chk("t1_done",    64'(done),    64'd1);
        chk("t1_entries", 64'(entries), 64'd7);
        for (int i = 0; i < 7; i++) rd_chk("t1_rd", 3'(i), 64'(i + 1));
        rd_chk("t1_rd_oob", 3'd7, 64'd0);

        // Wrap: value 12, post 3 -> 15 stored, oldest 8 survives.
        trig_value = 32'd12;
        do_arm(4'd3);
        chk("t2_entries_cleared", 64'(entries), 64'd0);
        feed(1, 20);
        chk("t2_state",   64'(state),   64'd3);
        chk("t2_entries", 64'(entries), 64'd8);
        for (int i = 0; i < 8; i++) rd_chk("t2_rd", 3'(i), 64'(i + 8));

        // Mask zero, post 0: first sample triggers and finishes.
        trig_mask = '0;
        do_arm(4'd0);
        sample_valid = 1'b1;
        sample_data  = 32'hAB;
        tick();
        sample_valid = 1'b0;
        chk("t3_state",   64'(state),   64'd3);
        chk("t3_entries", 64'(entries), 64'd1);
        rd_chk("t3_rd0", 3'd0, 64'hAB);
        rd_chk("t3_rd1", 3'd1, 64'd0);

        // post_count 15 clamps to 7: trigger at 3, samples 4..10 follow.
        trig_mask  = 32'hFFFF_FFFF;
        trig_value = 32'd3;
        do_arm(4'd15);
        feed(1, 9);
        chk("t4_after6", 64'(state), 64'd2);
        feed(10, 10);
        chk("t4_state",   64'(state),   64'd3);
        chk("t4_entries", 64'(entries), 64'd8);
        rd_chk("t4_rd0", 3'd0, 64'd3);
        rd_chk("t4_rd7", 3'd7, 64'd10);
        feed(11, 12);
        chk("t4_done_ignores", 64'(entries), 64'd8);

        // arm+abort together while TRIGGERED -> IDLE, and IDLE ignores samples.
        trig_value = 32'd2;
        do_arm(4'd5);
        feed(1, 3);
        chk("t5_triggered", 64'(state), 64'd2);
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk("t5_abort_state",   64'(state),   64'd0);
        chk("t5_abort_entries", 64'(entries), 64'd0);
        feed(1, 2);
        chk("t5_idle_ignores", 64'(entries), 64'd0);

        // Async reset mid-TRIGGERED clears outputs without a clock edge.
        do_arm(4'd5);
        rd_addr = 3'd0;
        feed(1, 3);
        chk("t6_triggered", 64'(state), 64'd2);
        chk("t6_rd_before", 64'(rd_data), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_state",   64'(state),   64'd0);
        chk("t6_done",    64'(done),    64'd0);
        chk("t6_entries", 64'(entries), 64'd0);
        chk("t6_rd_data", 64'(rd_data), 64'd0);
        #3;
        reset = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
        // Timestamp: writes at edges 11 and 14 after reset capture counter values 10 and 13.
        trig_value = 32'hFFFF_0000;
        do_arm(4'd3);
        for (int i = 2; i <= 10; i++) tick();
        feed(32'h111, 32'h111);
        tick();
        tick();
        feed(32'h222, 32'h222);
        chk("ts_entries", 64'(entries), 64'd2);
        rd_chk("ts_rd0", 3'd0, {16'd0, 16'd10, 32'h111});
        rd_chk("ts_rd1", 3'd1, {16'd0, 16'd13, 32'h222});
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
